des_final_perm: RTL

Output end of the DES datapath: takes the 32-bit L/R halves after the last round, swaps them, applies the inverse of the initial permutation and delivers the 64-bit block through a 2-entry output buffer with valid/ready flow control. It sits after the round pipeline and is the mirror of the input stage that applies the initial permutation and drops key parity. It also maintains a running count of delivered blocks.

---
 rtl/des_final_perm_if.sv | 24 ++
 rtl/des_final_perm.sv | 87 ++++++++
 2 files changed

// File: rtl/des_final_perm_if.sv
// des_final_perm_if: block handshake bundle for the DES output stage.
//   in_valid/in_ready/l_in/r_in : upstream block from the last round (L16/R16)
//   out_valid/out_ready/data_out: downstream permuted 64-bit block
// Modports: slave  - the output stage itself
//           master - the environment around it (drives inputs, consumes output)
interface des_final_perm_if;
    logic        in_valid;
    logic        in_ready;
    logic [32:1] l_in;
    logic [32:1] r_in;
    logic        out_valid;
    logic        out_ready;
    logic [64:1] data_out;

    modport slave (
        input  in_valid, l_in, r_in, out_ready,
        output in_ready, out_valid, data_out
    );

    modport master (
        output in_valid, l_in, r_in, out_ready,
        input  in_ready, out_valid, data_out
    );
endinterface

// File: rtl/des_final_perm.sv
// des_final_perm: DES output stage. Swaps the final L/R halves, applies the
// inverse initial permutation and delivers the block through a 2-entry FIFO
// with valid/ready flow control. Counts delivered blocks.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   flush   : synchronous clear of buffered blocks (counter untouched)
//   bus     : block handshake (slave modport of des_final_perm_if)
//   blk_cnt : number of output handshakes, wraps at 2^CNT_W
module des_final_perm #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    des_final_perm_if.slave   bus,
    output logic [CNT_W-1:0]  blk_cnt
);

    // Destination bit of pre-output word bit k (1-based, MSB = 64).
    function automatic int unsigned perm_idx(input int unsigned k);
        int unsigned g;
        int unsigned j;
        g = (k - 1) / 8;
        j = (k - 1) % 8;
        return 58 + 2 * (g % 4) - 8 * j - ((g >= 4) ? 1 : 0);
    endfunction

    logic [64:1] w;
    logic [64:1] perm;
    logic [64:1] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    assign w = {bus.r_in, bus.l_in};

    always_comb begin
        perm = '0;
        for (int unsigned k = 1; k <= 64; k++) begin
            perm[perm_idx(k)] = w[k];
        end
    end

    // in_ready depends only on the registered count, never on out_ready.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    // Gating by out_valid gives data_out = 0 after reset without clearing storage.
    assign bus.data_out  = bus.out_valid ? mem[rd_ptr] : '0;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= perm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            blk_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                blk_cnt <= blk_cnt + CNT_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
